tf_quan_offset_unit: RTL and testbench
======================================

# tf_quan_offset_unit

Multi-channel successor to the single-channel TF quantization offset block. It accumulates unsigned neuron activations per channel across a stage and, at stage end, multiplies each channel sum by that channel's weight zero point. Results are presented on a valid/ready output for the requantization stage. It sits between the activation output of the PE array and the layer's requantization pipeline, with one shared multiplier time-multiplexed over the channels.

## Interface
- NEURON_ACTIV_BIT_WIDTH, 8: unsigned activation width per channel.
- QUAN_WEIGHT_ZERO_BIT_WIDTH, 8: unsigned weight zero-point width per channel.
- NUM_CHANNELS, 4: number of parallel channels (≥1).
- SUM_QUAN_OFFSET_BIT_WIDTH, 20: per-channel accumulator width.
- QUAN_SCALE_BIT_WIDTH, 28: per-channel result width; must be ≥ SUM_QUAN_OFFSET_BIT_WIDTH + QUAN_WEIGHT_ZERO_BIT_WIDTH.
- clk  in  1  clock, all logic on rising edge.
- layer_reset_n  in  1  synchronous, active-low reset.
- tf_quantization_en_i  in  1  activation beat valid.
- tf_quantization_ready_o  out  1  beat accepted when en_i && ready_o.
- stage_finish_i  in  1  qualifies the current beat as the last of the stage.
- neuron_activation_i  in  NUM_CHANNELS*NEURON_ACTIV_BIT_WIDTH  channel c at slice c.
- quan_weight_zero_i  in  NUM_CHANNELS*QUAN_WEIGHT_ZERO_BIT_WIDTH  per-channel weight zero points.
- quan_scale_o  out  NUM_CHANNELS*QUAN_SCALE_BIT_WIDTH  per-channel sum × zero point.
- quan_scale_valid_o  out  1  result valid.
- quan_scale_ready_i  in  1  consumer accepts the result.
- quan_sum_sat_o  out  NUM_CHANNELS  per-channel saturation flag, qualified by valid_o.

## Operation
- FSM states:
  - ACCUM: ready_o = 1.
  - MULT: ready_o = 0; a channel counter runs 0..NUM_CHANNELS-1.
  - HOLD: ready_o = 0, valid_o = 1.
- ACCUM, accepted beat without finish: sum[c] += activation[c].
- ACCUM, accepted beat with finish:
  - Snapshot bank[c] ← sum[c] + activation[c]. The finish beat is included.
  - zw_bank ← quan_weight_zero_i.
  - sum[c] ← 0.
  - Clear the sat flags into the bank copy.
  - Counter ← 0; go to MULT.
- stage_finish_i is ignored unless the beat is accepted.
- MULT: each cycle, quan_scale[k] ← bank[k] × zw_bank[k], zero-extended to QUAN_SCALE_BIT_WIDTH. After k = NUM_CHANNELS-1, go to HOLD.
- HOLD: quan_scale_o and quan_sum_sat_o stay stable. On valid_o && ready_i, go to ACCUM.
- Arithmetic: all operands unsigned. The product is exact, with no truncation, given the width rule on QUAN_SCALE_BIT_WIDTH.
- Reset (layer_reset_n = 0 at an edge, in any state, including mid-MULT or HOLD):
  - Sums, banks, quan_scale_o, and sat flags cleared to 0.
  - valid_o = 0; state ACCUM; ready_o = 1 from the first cycle after reset deasserts.
  - A beat presented during reset is dropped.

## Timing
- Finish beat accepted in cycle T.
- MULT occupies cycles T+1 .. T+NUM_CHANNELS; channel k is written at the end of cycle T+1+k.
- valid_o rises in cycle T+NUM_CHANNELS+1. Latency = NUM_CHANNELS+1 cycles.
- If ready_i is already high, handshake occurs in cycle T+NUM_CHANNELS+1. ready_o returns high in cycle T+NUM_CHANNELS+2, which is the minimum stage-to-stage gap.
- ready_o depends only on state, not combinationally on en_i or stage_finish_i.
- A single-beat stage (finish on the first beat) is legal.

## Configuration
- TF_QUAN_SAT_EN defined:
  - Each accumulator saturates at 2^SUM_QUAN_OFFSET_BIT_WIDTH−1.
  - The channel's sticky sat flag sets and is reported in quan_sum_sat_o for that stage.
- TF_QUAN_SAT_EN undefined:
  - Accumulators wrap modulo 2^SUM_QUAN_OFFSET_BIT_WIDTH.
  - quan_sum_sat_o is tied to 0.

## Structure
- Shared package tf_quan_pkg holds:
  - the FSM state enum (ACCUM, MULT, HOLD);
  - default width constants;
  - a function returning the required QUAN_SCALE width, used in an elaboration check.
- Sub-module tf_quan_channel_acc: one accumulator with the saturation option and sticky flag, generated NUM_CHANNELS times. The top holds the FSM, counter, banks, and shared multiplier.

## Test plan
- Basic accumulate:
  - Stimulus: NUM_CHANNELS=4. Channel 0 activations 10, 20, 30, with finish on the 30 beat; zw0 = 3.
  - Response: quan_scale[0] = 180; valid_o rises 5 cycles after the finish beat.
- Single-beat stage:
  - Stimulus: activation 7 with finish; zw = 2.
  - Response: quan_scale = 14. Next stage sums restart from 0.
- Backpressure:
  - Stimulus: quan_scale_ready_i held low for 5 cycles in HOLD.
  - Response: outputs stable; ready_o = 0 throughout; en_i beats not accepted; accept on the cycle ready_i rises.
- Saturation with TF_QUAN_SAT_EN:
  - Stimulus: 4200 beats of 255 on channel 1; zw = 1.
  - Response: quan_scale[1] = 1048575 and sat[1] = 1. Without the macro: 22424 and sat = 0.
- Reset mid-MULT:
  - Stimulus: layer_reset_n low for 1 cycle at counter = 2.
  - Response: valid_o = 0, outputs 0, ready_o = 1 the next cycle. A following stage of 5,5 with finish and zw = 4 gives 40.
- Dropped finish:
  - Stimulus: stage_finish_i high with en_i low, or during MULT.
  - Response: no state change; accumulation continues.

Source files
------------

// File: rtl/tf_quan_pkg.sv
// tf_quan_pkg: shared types and constants for the TF quantization offset unit.
//   - tf_quan_state_e      : control FSM states (ACCUM, MULT, HOLD)
//   - DEF_*                : default widths and channel count
//   - tf_quan_req_scale_w  : minimum result width that keeps sum x zero point exact
package tf_quan_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    MULT  = 2'd1,
    HOLD  = 2'd2
  } tf_quan_state_e;

  localparam int DEF_NEURON_ACTIV_BIT_WIDTH     = 8;
  localparam int DEF_QUAN_WEIGHT_ZERO_BIT_WIDTH = 8;
  localparam int DEF_NUM_CHANNELS               = 4;
  localparam int DEF_SUM_QUAN_OFFSET_BIT_WIDTH  = 20;
  localparam int DEF_QUAN_SCALE_BIT_WIDTH       = 28;

  function automatic int tf_quan_req_scale_w(input int sum_w, input int zw_w);
    return sum_w + zw_w;
  endfunction

endpackage

// File: rtl/tf_quan_channel_acc.sv
// tf_quan_channel_acc: one per-channel activation accumulator.
// Ports:
//   clk, layer_reset_n : clock, synchronous active-low reset
//   acc_en_i           : accepted beat, add act_i into the running sum
//   clear_i            : accepted stage-final beat, restart sum and sticky flag at 0
//   act_i              : unsigned activation for this channel
//   sum_nxt_o          : running sum including act_i (the value a stage-final beat snapshots)
//   sat_nxt_o          : sticky saturation flag including act_i
// Macro TF_QUAN_SAT_EN: when defined the sum clamps at all-ones and a sticky flag is
// kept; when undefined the sum wraps and sat_nxt_o is constant 0.
module tf_quan_channel_acc #(
  parameter int ACT_W = 8,
  parameter int SUM_W = 20
) (
  input  logic             clk,
  input  logic             layer_reset_n,
  input  logic             acc_en_i,
  input  logic             clear_i,
  input  logic [ACT_W-1:0] act_i,
  output logic [SUM_W-1:0] sum_nxt_o,
  output logic             sat_nxt_o
);

  logic [SUM_W-1:0] sum_q, sum_d;

`ifdef TF_QUAN_SAT_EN
  logic             sat_q, sat_d;
  logic [SUM_W:0]   add_res;

  // Returns {overflow, clamped sum}; one extra bit catches the carry out.
  function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] a,
                                             input logic [ACT_W-1:0] b);
    logic [SUM_W:0] full;
    full = {1'b0, a} + (SUM_W+1)'(b);
    if (full[SUM_W]) sat_add = {1'b1, {SUM_W{1'b1}}};
    else             sat_add = full;
  endfunction

  assign add_res   = sat_add(sum_q, act_i);
  assign sum_nxt_o = add_res[SUM_W-1:0];
  assign sat_nxt_o = sat_q | add_res[SUM_W];

  always_comb begin
    sat_d = sat_q;
    if (clear_i)       sat_d = 1'b0;
    else if (acc_en_i) sat_d = sat_nxt_o;
  end

  always_ff @(posedge clk) begin
    if (!layer_reset_n) sat_q <= 1'b0;
    else                sat_q <= sat_d;
  end
`else
  assign sum_nxt_o = sum_q + SUM_W'(act_i);
  assign sat_nxt_o = 1'b0;
`endif

  always_comb begin
    sum_d = sum_q;
    if (clear_i)       sum_d = '0;
    else if (acc_en_i) sum_d = sum_nxt_o;
  end

  always_ff @(posedge clk) begin
    if (!layer_reset_n) sum_q <= '0;
    else                sum_q <= sum_d;
  end

endmodule

// File: rtl/tf_quan_offset_unit.sv
// tf_quan_offset_unit: multi-channel TF quantization offset.
// Accumulates unsigned activations per channel over a stage; on the stage-final beat
// the sums and weight zero points are banked, then one shared multiplier produces
// bank[k] * zw[k] for k = 0..NUM_CHANNELS-1 (one channel per cycle) and the result is
// held on a valid/ready output until the consumer takes it.
// Ports:
//   clk, layer_reset_n       : clock, synchronous active-low reset
//   tf_quantization_en_i     : activation beat valid
//   tf_quantization_ready_o  : beat accepted when en_i && ready_o (high only in ACCUM)
//   stage_finish_i           : marks the accepted beat as the last of the stage
//   neuron_activation_i      : NUM_CHANNELS packed activations
//   quan_weight_zero_i       : NUM_CHANNELS packed weight zero points
//   quan_scale_o             : NUM_CHANNELS packed sum x zero point results
//   quan_scale_valid_o / quan_scale_ready_i : result handshake
//   quan_sum_sat_o           : per-channel saturation flags, qualified by valid
// Macro TF_QUAN_SAT_EN: saturating accumulators with sticky flags; undefined -> wrap,
// flags constant 0.
module tf_quan_offset_unit
  import tf_quan_pkg::*;
#(
  parameter int NEURON_ACTIV_BIT_WIDTH     = DEF_NEURON_ACTIV_BIT_WIDTH,
  parameter int QUAN_WEIGHT_ZERO_BIT_WIDTH = DEF_QUAN_WEIGHT_ZERO_BIT_WIDTH,
  parameter int NUM_CHANNELS               = DEF_NUM_CHANNELS,
  parameter int SUM_QUAN_OFFSET_BIT_WIDTH  = DEF_SUM_QUAN_OFFSET_BIT_WIDTH,
  parameter int QUAN_SCALE_BIT_WIDTH       = DEF_QUAN_SCALE_BIT_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         layer_reset_n,
  input  logic                                         tf_quantization_en_i,
  output logic                                         tf_quantization_ready_o,
  input  logic                                         stage_finish_i,
  input  logic [NUM_CHANNELS*NEURON_ACTIV_BIT_WIDTH-1:0]     neuron_activation_i,
  input  logic [NUM_CHANNELS*QUAN_WEIGHT_ZERO_BIT_WIDTH-1:0] quan_weight_zero_i,
  output logic [NUM_CHANNELS*QUAN_SCALE_BIT_WIDTH-1:0]       quan_scale_o,
  output logic                                         quan_scale_valid_o,
  input  logic                                         quan_scale_ready_i,
  output logic [NUM_CHANNELS-1:0]                      quan_sum_sat_o
);

  localparam int NA = NEURON_ACTIV_BIT_WIDTH;
  localparam int ZW = QUAN_WEIGHT_ZERO_BIT_WIDTH;
  localparam int NC = NUM_CHANNELS;
  localparam int SW = SUM_QUAN_OFFSET_BIT_WIDTH;
  localparam int QW = QUAN_SCALE_BIT_WIDTH;
  localparam int PW = SW + ZW;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NC - 1);

  if (QW < tf_quan_req_scale_w(SW, ZW)) begin : g_width_chk
    $error("QUAN_SCALE_BIT_WIDTH too narrow for an exact sum x zero point product");
  end

  tf_quan_state_e   state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [SW-1:0]    bank_q  [NC];
  logic [SW-1:0]    bank_d  [NC];
  logic [ZW-1:0]    zw_q    [NC];
  logic [ZW-1:0]    zw_d    [NC];
  logic [QW-1:0]    scale_q [NC];
  logic [QW-1:0]    scale_d [NC];
  logic [NC-1:0]    sat_q, sat_d;

  logic [SW-1:0]    sum_nxt [NC];
  logic [NC-1:0]    sat_nxt;
  logic             accept;
  logic             stage_end;
  logic [PW-1:0]    prod;

  // ready_q is high exactly in ACCUM, so acceptance never depends on en_i combinationally.
  assign accept    = tf_quantization_en_i & ready_q;
  assign stage_end = accept & stage_finish_i;

  for (genvar c = 0; c < NC; c++) begin : g_ch
    tf_quan_channel_acc #(
      .ACT_W (NA),
      .SUM_W (SW)
    ) u_acc (
      .clk           (clk),
      .layer_reset_n (layer_reset_n),
      .acc_en_i      (accept),
      .clear_i       (stage_end),
      .act_i         (neuron_activation_i[c*NA +: NA]),
      .sum_nxt_o     (sum_nxt[c]),
      .sat_nxt_o     (sat_nxt[c])
    );
    assign quan_scale_o[c*QW +: QW] = scale_q[c];
  end

  // Single multiplier shared across channels, steered by the MULT counter.
  assign prod = PW'(bank_q[cnt_q]) * PW'(zw_q[cnt_q]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    valid_d = valid_q;
    bank_d  = bank_q;
    zw_d    = zw_q;
    scale_d = scale_q;
    sat_d   = sat_q;
    unique case (state_q)
      ACCUM: begin
        if (stage_end) begin
          // Snapshot includes the final beat; the accumulators clear on the same edge.
          for (int c = 0; c < NC; c++) begin
            bank_d[c] = sum_nxt[c];
            zw_d[c]   = quan_weight_zero_i[c*ZW +: ZW];
          end
          sat_d   = sat_nxt;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = MULT;
        end
      end
      MULT: begin
        scale_d[cnt_q] = QW'(prod);
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (quan_scale_ready_i) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = ACCUM;
        end
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!layer_reset_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      sat_q   <= '0;
      for (int c = 0; c < NC; c++) begin
        bank_q[c]  <= '0;
        zw_q[c]    <= '0;
        scale_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      bank_q  <= bank_d;
      zw_q    <= zw_d;
      scale_q <= scale_d;
    end
  end

  assign tf_quantization_ready_o = ready_q;
  assign quan_scale_valid_o      = valid_q;
  assign quan_sum_sat_o          = sat_q;

endmodule

// File: tb/tb_tf_quan_offset_unit.sv
// Testbench for tf_quan_offset_unit with a per-stage arithmetic reference model.
module tb_tf_quan_offset_unit;

  localparam int NA = 8;
  localparam int ZW = 8;
  localparam int NC = 4;
  localparam int SW = 20;
  localparam int QW = 28;
  localparam longint SMAX = (longint'(1) << SW) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               fin;
  logic               rdy_i;
  logic [NC*NA-1:0]   act;
  logic [NC*ZW-1:0]   zw;
  logic               ready_o;
  logic               valid_o;
  logic [NC*QW-1:0]   scale;
  logic [NC-1:0]      sat;

  int checks = 0;
  int errors = 0;

  longint        msum [NC];
  longint        exp_scale [NC];
  logic [NC-1:0] exp_sat;

  always #5 clk = ~clk;

  tf_quan_offset_unit dut (
    .clk                     (clk),
    .layer_reset_n           (rst_n),
    .tf_quantization_en_i    (en),
    .tf_quantization_ready_o (ready_o),
    .stage_finish_i          (fin),
    .neuron_activation_i     (act),
    .quan_weight_zero_i      (zw),
    .quan_scale_o            (scale),
    .quan_scale_valid_o      (valid_o),
    .quan_scale_ready_i      (rdy_i),
    .quan_sum_sat_o          (sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      msum[c]      = 0;
      exp_scale[c] = 0;
    end
    exp_sat = '0;
  endtask

  // Reference: sum of all accepted activations, clamped (or wrapped) once, times zw.
  task automatic model_accept(input logic [NC*NA-1:0] a, input logic [NC*ZW-1:0] z,
                              input bit f);
    longint v;
    for (int c = 0; c < NC; c++) msum[c] += longint'(a[c*NA +: NA]);
    if (f) begin
      for (int c = 0; c < NC; c++) begin
`ifdef TF_QUAN_SAT_EN
        exp_sat[c] = (msum[c] > SMAX);
        v = (msum[c] > SMAX) ? SMAX : msum[c];
`else
        exp_sat[c] = 1'b0;
        v = msum[c] % (SMAX + 1);
`endif
        exp_scale[c] = v * longint'(z[c*ZW +: ZW]);
        msum[c] = 0;
      end
    end
  endtask

  // Presents one beat for one cycle; the model follows only if the DUT was ready.
  task automatic beat(input logic [NC*NA-1:0] a, input logic [NC*ZW-1:0] z, input bit f);
    bit acc;
    act = a; zw = z; fin = f; en = 1'b1;
    acc = ready_o && rst_n;
    tick();
    en = 1'b0; fin = 1'b0;
    if (acc) model_accept(a, z, f);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_o && n < 50) begin
      tick();
      n++;
    end
    if (!valid_o) n = -1;
  endtask

  task automatic handshake(input int delay);
    rdy_i = 1'b0;
    for (int i = 0; i < delay; i++) tick();
    rdy_i = 1'b1;
    tick();
    rdy_i = 1'b0;
  endtask

  function automatic logic [NC*NA-1:0] rnd_act();
    logic [NC*NA-1:0] a;
    for (int c = 0; c < NC; c++) a[c*NA +: NA] = NA'($urandom);
    return a;
  endfunction

  function automatic logic [NC*ZW-1:0] rnd_zw();
    logic [NC*ZW-1:0] z;
    for (int c = 0; c < NC; c++) z[c*ZW +: ZW] = ZW'($urandom);
    return z;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; fin = 1'b1; act = rnd_act(); zw = rnd_zw(); rdy_i = 1'b0;
    repeat (3) tick();
    en = 1'b0; fin = 1'b0; rst_n = 1'b1;
    model_reset();
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++;
    if (scale !== '0) begin errors++; $display("FAIL reset_scale: got %h expected 0", scale); end
    checks++;
    if (sat !== '0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat); end
  endtask

  task automatic test_basic_accumulate();
    logic [NC*NA-1:0] a;
    logic [NC*ZW-1:0] z;
    int n;
    int vals [3] = '{10, 20, 30};
    z = rnd_zw(); z[0 +: ZW] = 8'd3;
    for (int i = 0; i < 3; i++) begin
      a = rnd_act(); a[0 +: NA] = NA'(vals[i]);
      beat(a, z, i == 2);
    end
    wait_valid(n);
    checks++;
    if (n !== NC) begin errors++; $display("FAIL basic_latency: got %0d cycles expected %0d", n, NC); end
    checks++;
    if (scale[0 +: QW] !== QW'(180)) begin
      errors++; $display("FAIL basic_ch0: got %0d expected 180", scale[0 +: QW]);
    end
    for (int c = 1; c < NC; c++) begin
      checks++;
      if (scale[c*QW +: QW] !== QW'(exp_scale[c])) begin
        errors++; $display("FAIL basic_ch%0d: got %0d expected %0d", c, scale[c*QW +: QW], exp_scale[c]);
      end
    end
    handshake(0);
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_release: ready %b valid %b expected 1 0", ready_o, valid_o);
    end
  endtask

  task automatic test_single_beat();
    logic [NC*NA-1:0] a;
    logic [NC*ZW-1:0] z;
    int n;
    a = '0; a[0 +: NA] = 8'd7;
    z = '0; z[0 +: ZW] = 8'd2;
    beat(a, z, 1'b1);
    wait_valid(n);
    checks++;
    if (n !== NC || scale[0 +: QW] !== QW'(14)) begin
      errors++; $display("FAIL single_beat: got %0d after %0d cycles expected 14 after %0d", scale[0 +: QW], n, NC);
    end
    handshake(1);
    a[0 +: NA] = 8'd5; z[0 +: ZW] = 8'd1;
    beat(a, z, 1'b1);
    wait_valid(n);
    checks++;
    if (scale[0 +: QW] !== QW'(5)) begin
      errors++; $display("FAIL single_restart: got %0d expected 5", scale[0 +: QW]);
    end
    handshake(0);
  endtask

  task automatic test_backpressure();
    logic [NC*QW-1:0] snap;
    int n;
    int bad = 0;
    beat(rnd_act(), rnd_zw(), 1'b0);
    beat(rnd_act(), rnd_zw(), 1'b1);
    wait_valid(n);
    snap = scale;
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (scale[c*QW +: QW] !== QW'(exp_scale[c])) begin
        errors++; $display("FAIL bp_ch%0d: got %0d expected %0d", c, scale[c*QW +: QW], exp_scale[c]);
      end
    end
    rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || scale !== snap) begin
        errors++; bad++;
        $display("FAIL bp_hold%0d: ready %b valid %b scale %h expected 0 1 %h", i, ready_o, valid_o, scale, snap);
      end
      beat(rnd_act(), rnd_zw(), 1'b1);
    end
    rdy_i = 1'b1;
    tick();
    rdy_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_accept: ready %b valid %b expected 1 0", ready_o, valid_o);
    end
    // A fresh stage must not contain any of the beats offered during HOLD.
    beat(rnd_act(), rnd_zw(), 1'b1);
    wait_valid(n);
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (scale[c*QW +: QW] !== QW'(exp_scale[c])) begin
        errors++; $display("FAIL bp_next_ch%0d: got %0d expected %0d", c, scale[c*QW +: QW], exp_scale[c]);
      end
    end
    handshake(0);
  endtask

  task automatic test_saturation();
    logic [NC*NA-1:0] a;
    logic [NC*ZW-1:0] z;
    int n;
    a = '0; a[NA +: NA] = 8'd255;
    z = '0; z[ZW +: ZW] = 8'd1;
    for (int i = 0; i < 4200; i++) beat(a, z, i == 4199);
    wait_valid(n);
    checks++;
`ifdef TF_QUAN_SAT_EN
    if (scale[QW +: QW] !== QW'(1048575) || sat[1] !== 1'b1) begin
      errors++; $display("FAIL sat_ch1: got %0d sat %b expected 1048575 sat 1", scale[QW +: QW], sat[1]);
    end
`else
    if (scale[QW +: QW] !== QW'(22424) || sat[1] !== 1'b0) begin
      errors++; $display("FAIL sat_ch1: got %0d sat %b expected 22424 sat 0", scale[QW +: QW], sat[1]);
    end
`endif
    checks++;
    if (sat !== exp_sat) begin errors++; $display("FAIL sat_flags: got %b expected %b", sat, exp_sat); end
    handshake(0);
  endtask

  task automatic test_reset_mid_mult();
    logic [NC*NA-1:0] a;
    logic [NC*ZW-1:0] z;
    int n;
    beat(rnd_act(), rnd_zw(), 1'b0);
    beat(rnd_act(), rnd_zw(), 1'b1);
    tick();
    tick();
    rst_n = 1'b0; en = 1'b1; act = rnd_act();
    tick();
    rst_n = 1'b1; en = 1'b0;
    model_reset();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || scale !== '0 || sat !== '0) begin
      errors++; $display("FAIL mid_mult_reset: valid %b ready %b scale %h sat %b expected 0 1 0 0", valid_o, ready_o, scale, sat);
    end
    a = '0; a[0 +: NA] = 8'd5;
    z = '0; z[0 +: ZW] = 8'd4;
    beat(a, z, 1'b0);
    beat(a, z, 1'b1);
    wait_valid(n);
    checks++;
    if (n !== NC || scale[0 +: QW] !== QW'(40)) begin
      errors++; $display("FAIL mid_mult_next: got %0d after %0d cycles expected 40 after %0d", scale[0 +: QW], n, NC);
    end
    handshake(0);
  endtask

  task automatic test_dropped_finish();
    int n;
    beat(rnd_act(), rnd_zw(), 1'b0);
    en = 1'b0; fin = 1'b1;
    tick();
    tick();
    fin = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("FAIL drop_idle: ready %b valid %b expected 1 0", ready_o, valid_o);
    end
    beat(rnd_act(), rnd_zw(), 1'b0);
    beat(rnd_act(), rnd_zw(), 1'b1);
    beat(rnd_act(), rnd_zw(), 1'b1);
    wait_valid(n);
    checks++;
    if (n !== NC - 1) begin errors++; $display("FAIL drop_latency: got %0d expected %0d", n, NC - 1); end
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (scale[c*QW +: QW] !== QW'(exp_scale[c])) begin
        errors++; $display("FAIL drop_ch%0d: got %0d expected %0d", c, scale[c*QW +: QW], exp_scale[c]);
      end
    end
    handshake(0);
  endtask

  task automatic test_random_stages();
    int n;
    int len;
    for (int s = 0; s < 20; s++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          en = 1'b0; fin = 1'(($urandom));
          tick();
          fin = 1'b0;
        end
        beat(rnd_act(), rnd_zw(), i == len - 1);
      end
      wait_valid(n);
      checks++;
      if (n !== NC) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", s, n, NC); end
      for (int c = 0; c < NC; c++) begin
        checks++;
        if (scale[c*QW +: QW] !== QW'(exp_scale[c])) begin
          errors++; $display("FAIL rand%0d_ch%0d: got %0d expected %0d", s, c, scale[c*QW +: QW], exp_scale[c]);
        end
      end
      checks++;
      if (sat !== exp_sat) begin errors++; $display("FAIL rand%0d_sat: got %b expected %b", s, sat, exp_sat); end
      handshake($urandom_range(0, 3));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; fin = 1'b0; rdy_i = 1'b0; act = '0; zw = '0;
    test_reset();
    test_basic_accumulate();
    test_single_beat();
    test_backpressure();
    test_saturation();
    test_reset_mid_mult();
    test_dropped_finish();
    test_random_stages();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
